// File: rtl/fifo_ring.sv
// fifo_ring: circular-buffer FIFO with show-ahead head word, occupancy level and
// programmable almost-full/almost-empty flags. Define FIFO_RING_ERR_FLAGS_EN for sticky overflow/underflow flags.
module fifo_ring #(
  parameter int data_width         = 32,
  parameter int size               = 32,
  parameter int almost_full_level  = size - 4,
  parameter int almost_empty_level = 4,
  localparam int LW = $clog2(size + 1),
  localparam int PW = $clog2(size)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  input  logic                  insert,
  input  logic                  next,
  input  logic                  clear,
  output logic [data_width-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  logic [data_width-1:0] mem [size];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;

  // Wrap explicitly at size-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] res;
    if (ptr == PW'(size - 1)) begin
      res = {PW{1'b0}};
    end else begin
      res = ptr + PW'(1);
    end
    return res;
  endfunction

  assign full_s  = (level_r == LW'(size));
  assign empty_s = (level_r == {LW{1'b0}});

  // Effective push/pop; reset and clear swallow any request in the same cycle.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (reset || clear) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = insert && (!full_s || next);
      pop_s  = next && !empty_s;
    end
  end

  // Storage write; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= data_in;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

`ifdef FIFO_RING_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags: a dropped request leaves FIFO state untouched.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (insert && full_s && !next) begin
        overflow_r <= 1'b1;
      end
      if (next && empty_s && !insert) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign data_out     = empty_s ? {data_width{1'b0}} : mem[rd_ptr_r];
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (level_r >= LW'(almost_full_level));
  assign almost_empty = (level_r <= LW'(almost_empty_level));
  assign level        = level_r;

endmodule

// File: tb/tb_fifo_ring.sv
// Scoreboard bench for fifo_ring (size 4, almost_full 3, almost_empty 1): stimulus queues
// hand-computed expected state, a negedge monitor compares it after the targeted clock edge.
module tb_fifo_ring;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       insert = 1'b0;
  logic       next = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] level;
  logic       overflow, underflow;

  fifo_ring #(
    .data_width(8), .size(4), .almost_full_level(3), .almost_empty_level(1)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .insert(insert), .next(next),
    .clear(clear), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
    logic [2:0] lvl;
    logic [3:0] flg;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vec_id = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that targets the edge just taken.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (data_out !== mon_e.data || level !== mon_e.lvl ||
          {full, empty, almost_full, almost_empty} !== mon_e.flg ||
          {overflow, underflow} !== mon_e.err) begin
        fails++;
        $display("FAIL vec%0d: got data=%h level=%0d f/e/af/ae=%b ovf/unf=%b, need data=%h level=%0d f/e/af/ae=%b ovf/unf=%b",
                 mon_e.id, data_out, level, {full, empty, almost_full, almost_empty},
                 {overflow, underflow}, mon_e.data, mon_e.lvl, mon_e.flg, mon_e.err);
      end
    end
  end

  // err is {overflow, underflow} as expected with the error-flag feature built in.
  task automatic step(input logic r, input logic i, input logic n, input logic c,
                      input logic [7:0] d, input logic [7:0] ed, input int el,
                      input logic [1:0] ee);
    exp_t x;
    @(negedge clk);
    reset   = r;
    insert  = i;
    next    = n;
    clear   = c;
    data_in = d;
    x.due  = cyc + 1;
    x.id   = vec_id;
    x.data = ed;
    x.lvl  = 3'(el);
    x.flg  = {el == 4, el == 0, el >= 3, el <= 1};
`ifdef FIFO_RING_ERR_FLAGS_EN
    x.err  = ee;
`else
    x.err  = 2'b00;
`endif
    vec_id++;
    exp_q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //    rst   ins   nxt   clr   din    data   lvl err
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 2'b00);
    // fill
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1, 8'hA1, 1, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2, 8'hA1, 2, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 8'hA1, 3, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA4, 8'hA1, 4, 2'b00);
    // drain
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 3, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 2, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA4, 1, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b00);
    // refill and drain across the pointer wrap
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB1, 8'hB1, 1, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 8'hB1, 2, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB3, 8'hB1, 3, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB4, 8'hB1, 4, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hB2, 3, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hB3, 2, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hB4, 1, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b00);
    // full plus insert+next
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1, 8'hA1, 1, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2, 8'hA1, 2, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 8'hA1, 3, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA4, 8'hA1, 4, 2'b00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hC0, 8'hA2, 4, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 3, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA4, 2, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hC0, 1, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b00);
    // empty plus insert+next
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'h55, 1, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b00);
    // underflow, held, then cleared
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b01);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 2'b01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0, 2'b00);
    // clear mid-stream drops the concurrent insert
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h11, 1, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h11, 2, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h11, 3, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00, 0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 2'b00);
    // overflow while full, contents unchanged
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 8'h66, 1, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h66, 2, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h88, 8'h66, 3, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 8'h66, 4, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, 8'h66, 4, 2'b10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h66, 4, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 3, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h88, 2, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 2'b11);
    // reset clears both flags; reset wins over a concurrent insert
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 2'b00);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
